// File: rtl/alarm_tone_gen_pkg.sv
// Shared types and constants for the alarm sounder back-end.
// Holds the state enum, zone ids and the per-zone cadence patterns.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SOUND,
    MUTED
  } state_t;

  localparam logic [1:0] ZONE_NONE = 2'd0;
  localparam logic [1:0] ZONE_1    = 2'd1;
  localparam logic [1:0] ZONE_2    = 2'd2;
  localparam logic [1:0] ZONE_3    = 2'd3;

  // Bit i is the on/off flag for beat i.
  localparam logic [3:0] PAT_Z1 = 4'b1111;
  localparam logic [3:0] PAT_Z2 = 4'b0101;
  localparam logic [3:0] PAT_Z3 = 4'b0011;

  function automatic logic [1:0] zone_sel(
    input logic [2:0] a
  );
    if (a[2])      return ZONE_3;
    else if (a[1]) return ZONE_2;
    else if (a[0]) return ZONE_1;
    else           return ZONE_NONE;
  endfunction

  function automatic logic [3:0] pattern(
    input logic [1:0] z
  );
    case (z)
      ZONE_1:  return PAT_Z1;
      ZONE_2:  return PAT_Z2;
      ZONE_3:  return PAT_Z3;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/alarm_tone_gen_if.sv
// Zone alarm inputs, mute request and sounder outputs.
// The master drives alarms and mute, the slave (sounder) drives outputs.
interface alarm_tone_gen_if;
  logic [2:0] alarm_in;
  logic       mute;
  logic       tone_out;
  logic       alarm_active;
  logic [1:0] alarm_id;

  modport master (
    output alarm_in, mute,
    input  tone_out, alarm_active, alarm_id
  );

  modport slave (
    input  alarm_in, mute,
    output tone_out, alarm_active, alarm_id
  );
endinterface

// File: rtl/alarm_tone_gen_tone_divider.sv
// Half-period counter and phase flop for the tone square wave.
// restart forces count 0 / phase 1; run advances the counter.
module tone_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [15:0] div,
  input  logic        restart,
  input  logic        run,
  output logic        phase
);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (ena) begin
      if (!rst_n) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (restart) begin
        cnt   <= '0;
        phase <= 1'b1;
      end else if (run) begin
        if (cnt == div - 16'd1) begin
          cnt   <= '0;
          phase <= ~phase;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/alarm_tone_gen.sv
// Alarm sounder: per-zone tone and cadence with timed mute.
// Outputs are registered from the current state, one cycle behind it.
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int TONE_DIV1  = 4,
  parameter int TONE_DIV2  = 3,
  parameter int TONE_DIV3  = 2,
  parameter int BEAT_LEN   = 16,
  parameter int MUTE_BEATS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  alarm_tone_gen_if.slave  bus
);

  localparam logic [23:0] BEAT_LAST = 24'(BEAT_LEN - 1);
  localparam logic [7:0]  MUTE_LAST = 8'(MUTE_BEATS - 1);

  state_t      state, state_nxt;
  logic [1:0]  id, id_nxt, zone;
  logic [1:0]  beat, beat_nxt;
  logic [23:0] bcnt, bcnt_nxt;
  logic [7:0]  mcnt, mcnt_nxt;
  logic        restart, go_idle;
  logic        bwrap, mdone;
  logic [15:0] div;
  logic [3:0]  pat;
  logic        phase;

  assign zone  = zone_sel(bus.alarm_in);
  assign pat   = pattern(id);
  assign bwrap = (bcnt == BEAT_LAST);
  assign mdone = bwrap && (mcnt == MUTE_LAST);

  always_comb begin
    case (id)
      ZONE_2:  div = 16'(TONE_DIV2);
      ZONE_3:  div = 16'(TONE_DIV3);
      default: div = 16'(TONE_DIV1);
    endcase
  end

  tone_divider u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .div     (div),
    .restart (restart),
    .run     (state == SOUND),
    .phase   (phase)
  );

  always_comb begin
    state_nxt = state;
    id_nxt    = id;
    beat_nxt  = beat;
    bcnt_nxt  = bwrap ? 24'd0 : bcnt + 24'd1;
    mcnt_nxt  = mcnt;
    restart   = 1'b0;
    go_idle   = 1'b0;
    case (state)
      IDLE: begin
        bcnt_nxt = '0;
        if (zone != ZONE_NONE) restart = 1'b1;
      end
      SOUND: begin
        if (zone == ZONE_NONE) go_idle = 1'b1;
        else if (zone != id) restart = 1'b1;
        else if (bus.mute) begin
          state_nxt = MUTED;
          bcnt_nxt  = '0;
          mcnt_nxt  = '0;
        end else if (bwrap) beat_nxt = beat + 2'd1;
      end
      MUTED: begin
        // A new zone breaks the mute; repeated mute requests are ignored.
        if (zone == ZONE_NONE) go_idle = 1'b1;
        else if (zone != id || mdone) restart = 1'b1;
        else if (bwrap) mcnt_nxt = mcnt + 8'd1;
      end
      default: go_idle = 1'b1;
    endcase
    if (restart) begin
      state_nxt = SOUND;
      id_nxt    = zone;
      beat_nxt  = '0;
      bcnt_nxt  = '0;
      mcnt_nxt  = '0;
    end
    if (go_idle) begin
      state_nxt = IDLE;
      id_nxt    = ZONE_NONE;
      beat_nxt  = '0;
      bcnt_nxt  = '0;
      mcnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (ena) begin
      if (!rst_n) begin
        state            <= IDLE;
        id               <= ZONE_NONE;
        beat             <= '0;
        bcnt             <= '0;
        mcnt             <= '0;
        bus.tone_out     <= 1'b0;
        bus.alarm_active <= 1'b0;
        bus.alarm_id     <= ZONE_NONE;
      end else begin
        state            <= state_nxt;
        id               <= id_nxt;
        beat             <= beat_nxt;
        bcnt             <= bcnt_nxt;
        mcnt             <= mcnt_nxt;
        bus.tone_out     <= (state == SOUND) && phase && pat[beat];
        bus.alarm_active <= (state != IDLE);
        bus.alarm_id     <= id;
      end
    end
  end

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Directed bench for alarm_tone_gen with default parameters.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_alarm_tone_gen;

  logic clk;
  logic rst_n;
  logic ena;
  int   checks;
  int   errors;

  alarm_tone_gen_if bus ();

  alarm_tone_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    bus.alarm_in = 3'b111;
    bus.mute = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.tone_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_tone got %b exp 0", bus.tone_out);
      end
      checks++;
      if (bus.alarm_active !== 1'b0) begin
        errors++;
        $display("FAIL reset_active got %b exp 0", bus.alarm_active);
      end
      checks++;
      if (bus.alarm_id !== 2'd0) begin
        errors++;
        $display("FAIL reset_id got %0d exp 0", bus.alarm_id);
      end
    end
    bus.alarm_in = 3'b000;
    bus.mute = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.tone_out, bus.alarm_active, bus.alarm_id} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset got %b exp 0000",
               {bus.tone_out, bus.alarm_active, bus.alarm_id});
    end
  endtask

  task automatic drop_and_check(input string name);
    bus.alarm_in = 3'b000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.tone_out, bus.alarm_active, bus.alarm_id} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_drop got %b exp 0000", name,
               {bus.tone_out, bus.alarm_active, bus.alarm_id});
    end
  endtask

  task automatic test_zone1();
    logic exp;
    bus.alarm_in = 3'b001;
    @(negedge clk);
    checks++;
    if (bus.alarm_id !== 2'd0) begin
      errors++;
      $display("FAIL z1_latency got %0d exp 0", bus.alarm_id);
    end
    @(negedge clk);
    checks++;
    if (bus.alarm_id !== 2'd1 || bus.alarm_active !== 1'b1) begin
      errors++;
      $display("FAIL z1_id got %0d/%b exp 1/1", bus.alarm_id, bus.alarm_active);
    end
    for (int j = 0; j < 128; j++) begin
      if (j > 0) @(negedge clk);
      exp = ((j / 4) % 2) == 0;
      checks++;
      if (bus.tone_out !== exp) begin
        errors++;
        $display("FAIL z1_tone[%0d] got %b exp %b", j, bus.tone_out, exp);
      end
    end
    drop_and_check("z1");
  endtask

  task automatic test_zone3();
    logic exp;
    bus.alarm_in = 3'b100;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.alarm_id !== 2'd3) begin
      errors++;
      $display("FAIL z3_id got %0d exp 3", bus.alarm_id);
    end
    for (int j = 0; j < 128; j++) begin
      if (j > 0) @(negedge clk);
      exp = (((j / 16) % 4) < 2) && (((j / 2) % 2) == 0);
      checks++;
      if (bus.tone_out !== exp) begin
        errors++;
        $display("FAIL z3_tone[%0d] got %b exp %b", j, bus.tone_out, exp);
      end
    end
    drop_and_check("z3");
  endtask

  task automatic test_zone_change();
    logic exp;
    bus.alarm_in = 3'b011;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.alarm_id !== 2'd2) begin
      errors++;
      $display("FAIL prio_id got %0d exp 2", bus.alarm_id);
    end
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      exp = ((j / 3) % 2) == 0;
      checks++;
      if (bus.tone_out !== exp) begin
        errors++;
        $display("FAIL z2_tone[%0d] got %b exp %b", j, bus.tone_out, exp);
      end
    end
    bus.alarm_in = 3'b001;
    @(negedge clk);
    checks++;
    if (bus.alarm_id !== 2'd2) begin
      errors++;
      $display("FAIL chg_lag got %0d exp 2", bus.alarm_id);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      exp = j < 4;
      checks++;
      if (bus.tone_out !== exp || bus.alarm_id !== 2'd1) begin
        errors++;
        $display("FAIL chg_z1[%0d] got %b/%0d exp %b/1",
                 j, bus.tone_out, bus.alarm_id, exp);
      end
    end
    drop_and_check("chg");
  endtask

  task automatic test_mute();
    logic exp;
    bus.alarm_in = 3'b010;
    @(negedge clk);
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      exp = ((j / 3) % 2) == 0;
      checks++;
      if (bus.tone_out !== exp) begin
        errors++;
        $display("FAIL m_pre[%0d] got %b exp %b", j, bus.tone_out, exp);
      end
    end
    bus.mute = 1'b1;
    @(negedge clk);
    bus.mute = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      checks++;
      if (bus.tone_out !== 1'b0 || bus.alarm_active !== 1'b1) begin
        errors++;
        $display("FAIL m_quiet[%0d] got %b/%b exp 0/1",
                 k, bus.tone_out, bus.alarm_active);
      end
      bus.mute = (k == 20);
    end
    @(negedge clk);
    checks++;
    if (bus.tone_out !== 1'b1 || bus.alarm_id !== 2'd2) begin
      errors++;
      $display("FAIL m_resume got %b/%0d exp 1/2", bus.tone_out, bus.alarm_id);
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      exp = i < 3;
      checks++;
      if (bus.tone_out !== exp) begin
        errors++;
        $display("FAIL m_post[%0d] got %b exp %b", i, bus.tone_out, exp);
      end
    end
    bus.mute = 1'b1;
    @(negedge clk);
    bus.mute = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (bus.tone_out !== 1'b0) begin
        errors++;
        $display("FAIL m2_quiet[%0d] got %b exp 0", k, bus.tone_out);
      end
    end
    bus.alarm_in = 3'b100;
    @(negedge clk);
    checks++;
    if (bus.alarm_id !== 2'd2 || bus.tone_out !== 1'b0) begin
      errors++;
      $display("FAIL m2_lag got %0d/%b exp 2/0", bus.alarm_id, bus.tone_out);
    end
    @(negedge clk);
    checks++;
    if ({bus.tone_out, bus.alarm_active, bus.alarm_id} !== 4'b1111) begin
      errors++;
      $display("FAIL m2_break got %b exp 1111",
               {bus.tone_out, bus.alarm_active, bus.alarm_id});
    end
    drop_and_check("mute");
  endtask

  task automatic test_ena();
    bus.alarm_in = 3'b001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.tone_out !== 1'b1 || bus.alarm_id !== 2'd1) begin
      errors++;
      $display("FAIL ena_pre got %b/%0d exp 1/1", bus.tone_out, bus.alarm_id);
    end
    ena = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.tone_out !== 1'b1 || bus.alarm_id !== 2'd1) begin
        errors++;
        $display("FAIL ena_frozen[%0d] got %b/%0d exp 1/1",
                 c, bus.tone_out, bus.alarm_id);
      end
    end
    ena = 1'b1;
    for (int j = 2; j < 6; j++) begin
      @(negedge clk);
      checks++;
      if (bus.tone_out !== (j < 4)) begin
        errors++;
        $display("FAIL ena_resume[%0d] got %b exp %b", j, bus.tone_out, j < 4);
      end
    end
    drop_and_check("ena");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ena = 1'b1;
    bus.alarm_in = 3'b000;
    bus.mute = 1'b0;
    test_reset();
    test_zone1();
    test_zone3();
    test_zone_change();
    test_mute();
    test_ena();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_tone_gen.md
# alarm_tone_gen

Alarm sounder back-end. It consumes the three level-type zone alarm lines produced by the sensor-confirmation stage, one per buzzer, and drives a single piezo pin. Each zone gets its own tone frequency and on/off cadence, and a mute input silences the sounder for a programmable time. It sits between the detector's buzzer outputs and the physical output pin.

## Interface
- `TONE_DIV1`, default 4: half-period of the zone-1 tone, in clk cycles (range 2..65535).
- `TONE_DIV2`, default 3: half-period of the zone-2 tone.
- `TONE_DIV3`, default 2: half-period of the zone-3 tone.
- `BEAT_LEN`, default 16: clk cycles per cadence beat (range 2..2^24-1).
- `MUTE_BEATS`, default 2: beats of silence after a mute request (range 1..255).
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `ena`, input, 1: clock enable. When low, all state holds.
- `alarm_in`, input, 3: zone alarm levels; bit0 = zone 1, bit2 = zone 3.
- `mute`, input, 1: single-cycle mute request.
- `tone_out`, output, 1: gated square wave to the piezo. Registered.
- `alarm_active`, output, 1: high in SOUND or MUTED. Registered.
- `alarm_id`, output, 2: zone currently served, 0 = none. Registered.

## Operation
- Reset values (rst_n low on a clk edge with ena high): state IDLE; `tone_out`, `alarm_active`, `alarm_id`, and all counters at 0. Reset is honoured only when ena is high.
- Zone select: the highest set bit of `alarm_in` wins (zone 3 > 2 > 1). The bench must treat inputs as nominally one-hot, but priority is mandatory.
- States:
  - IDLE: any zone asserted → SOUND. On entry, latch `alarm_id`, beat index=0, beat counter=0, tone counter=0, phase=1.
  - SOUND, selected zone changes to a different nonzero value → restart SOUND with the new id, applying the same entry values.
  - SOUND, `alarm_in`=0 → IDLE. `tone_out` goes to 0 and `alarm_id` to 0.
  - SOUND, `mute` → MUTED. Mute counter=0 and `tone_out`=0.
  - MUTED: after `MUTE_BEATS`×`BEAT_LEN` cycles, go to SOUND (restart) if a zone is asserted, else IDLE.
  - MUTED, zone changes to a different nonzero id → SOUND immediately. A new zone breaks the mute.
  - MUTED, `alarm_in`=0 → IDLE.
  - A `mute` pulse in IDLE or MUTED is ignored. It does not extend the mute.
- Tone generation:
  - The tone counter counts 0..TONE_DIVn-1. At TONE_DIVn-1 it wraps and the phase toggles.
  - The tone counter and phase run freely throughout SOUND and are not reset at beat boundaries.
- Cadence: a 2-bit beat index advances when the beat counter wraps at BEAT_LEN-1. Patterns over beats 0..3:
  - zone 1 = 1111 (continuous)
  - zone 2 = 1010
  - zone 3 = 1100
- Output: in SOUND, `tone_out` = phase AND pattern[beat index]; otherwise 0.
- Widths: tone counter 16 bit, beat counter 24 bit, mute counter 8 bit (counts beats). All wrap explicitly, with no overflow past the terminal value.

## Timing
- `alarm_in` is sampled at edge N. `alarm_id`, `alarm_active`, and `tone_out`=1 are visible after edge N+1.
- `tone_out` then holds for TONE_DIVn cycles per level: high TONE_DIVn, low TONE_DIVn.
- An alarm drop sampled at N gives all outputs 0 after N+1.
- A mute sampled at N gives `tone_out`=0 after N+1. Sound resumes at beat 0, phase 1, exactly MUTE_BEATS×BEAT_LEN cycles later.
- Simultaneous `mute` and zone change in SOUND: the zone change wins and SOUND restarts.
- Simultaneous `mute` and `alarm_in`=0: go to IDLE.
- ena low: counters, state, and outputs freeze. Operation resumes seamlessly when ena returns high.

## Structure
- Package `alarm_pkg`:
  - state enum IDLE/SOUND/MUTED
  - zone constants ZONE_NONE=0, ZONE_1..3
  - cadence pattern constants
- Sub-module `tone_divider`: 16-bit half-period counter plus phase flop, with inputs div, restart, run, and output phase. The top instantiates it once and muxes `div` from the latched `alarm_id`.

## Test plan
All scenarios use default parameters.
- rst_n low with `alarm_in`=111 and `mute`=1 → after the next edge all outputs are 0; this persists while reset is held.
- `alarm_in`=001 held → `alarm_id`=1 next cycle; `tone_out` runs 4 high / 4 low continuously for 128 cycles with no gaps.
- `alarm_in`=100 → `alarm_id`=3; `tone_out` toggles every 2 cycles during cycles 1..32, is 0 for cycles 33..64, then repeats.
- `alarm_in`=011 → `alarm_id`=2 at TONE_DIV2=3; then change to 001 mid-beat → `alarm_id`=1 next cycle and `tone_out`=1 (restart).
- Zone 2 active, `mute` pulse → `tone_out`=0 for 32 cycles, then resumes high at beat 0. Repeat with `alarm_in`→100 at mute cycle 10 → SOUND with `alarm_id`=3 next cycle.
- Zone 1 active, ena low for 10 cycles mid-high-phase → `tone_out` frozen high; the remaining high count completes after ena returns.
